// File: rtl/pc_jump_unit_pkg.sv
// pc_jump_unit_pkg
// Shared constants for the fetch-stage PC/jump logic.
//   PC_BUS       : PC / target width in bits
//   RESET_PC_DEF : default PC value loaded on reset
//   PCJ_RUN      : state encoding, no pending jump
//   PCJ_PEND     : state encoding, buffer holds a target
package pc_jump_unit_pkg;

  localparam int PC_BUS = 16;

  localparam logic [PC_BUS-1:0] RESET_PC_DEF = 16'h0000;

  localparam logic PCJ_RUN  = 1'b0;
  localparam logic PCJ_PEND = 1'b1;

endpackage

// File: rtl/pc_pend_buf.sv
// pc_pend_buf
// One-entry jump-target register with its valid flag. The valid flag is
// the RUN/PEND state bit of the jump unit.
// Ports:
//   clk    in  : clock, rising edge
//   rst    in  : synchronous active-low reset (clears valid only)
//   load   in  : capture d and set valid (wins over clear)
//   clear  in  : drop the buffered target
//   d      in  : target to capture
//   target out : buffered target
//   valid  out : buffer holds a target (state == PCJ_PEND)
module pc_pend_buf
  import pc_jump_unit_pkg::*;
#(
  parameter int PC_W = PC_BUS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic [PC_W-1:0] d,
  output logic [PC_W-1:0] target,
  output logic            valid
);

  logic            state_q;
  logic [PC_W-1:0] target_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= PCJ_RUN;
    end else if (load) begin
      state_q <= PCJ_PEND;
    end else if (clear) begin
      state_q <= PCJ_RUN;
    end
  end

  // Contents are don't-care when invalid, so no reset on the data path.
  always_ff @(posedge clk) begin
    if (load) begin
      target_q <= d;
    end
  end

  assign target = target_q;
  assign valid  = (state_q == PCJ_PEND);

endmodule

// File: rtl/pc_jump_unit.sv
// pc_jump_unit
// Fetch-stage program counter with jump consumer. Advances by one word per
// unstalled cycle, loads a jump target when execute raises a jump, and
// holds a jump that arrives during a stall in a one-entry buffer until the
// stall releases. Drives the IF/ID flush.
//
// Optional feature macro: PC_JUMP_COUNT_EN (applied-jump counter). When
// undefined the counter is not built and jump_count reads 16'h0000.
//
// Handshake: jump_valid is a single-cycle qualifier with no ready; a request
// is always accepted in the cycle it is raised, either applied (stall=0) or
// buffered (stall=1, newest buffered request wins).
//
// Ports:
//   clk        in  : clock, rising edge
//   rst        in  : synchronous active-low reset
//   jump_valid in  : jump request from execute
//   jump_addr  in  : jump target word address
//   stall      in  : freeze of PC/IF stage
//   pc         out : current fetch address (registered)
//   pc_plus1   out : pc + 1, wrapping (combinational)
//   flush      out : kill IF/ID instruction (combinational)
//   pend_valid out : pending jump buffered (registered, exposes FSM state)
//   jump_count out : saturating count of applied jumps
module pc_jump_unit
  import pc_jump_unit_pkg::*;
#(
  parameter int              PC_W     = PC_BUS,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            jump_valid,
  input  logic [PC_W-1:0] jump_addr,
  input  logic            stall,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus1,
  output logic            flush,
  output logic            pend_valid,
  output logic [15:0]     jump_count
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pend_target;
  logic            apply_live;
  logic            apply_pend;
  logic            buf_load;
  logic            buf_clear;

  // A live request beats a pending one; the pending entry is then dropped.
  assign apply_live = ~stall & jump_valid;
  assign apply_pend = ~stall & ~jump_valid & pend_valid;
  assign buf_load   = stall & jump_valid;
  assign buf_clear  = ~stall;

  pc_pend_buf #(
    .PC_W (PC_W)
  ) u_pend_buf (
    .clk    (clk),
    .rst    (rst),
    .load   (buf_load),
    .clear  (buf_clear),
    .d      (jump_addr),
    .target (pend_target),
    .valid  (pend_valid)
  );

  assign pc_plus1 = pc_q + PC_W'(1);

  always_comb begin
    pc_d = pc_plus1;
    if (stall) begin
      pc_d = pc_q;
    end else if (jump_valid) begin
      pc_d = jump_addr;
    end else if (pend_valid) begin
      pc_d = pend_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc    = pc_q;
  assign flush = rst & ~stall & (jump_valid | pend_valid);

`ifdef PC_JUMP_COUNT_EN
  logic [15:0] jump_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      jump_cnt_q <= 16'h0000;
    end else if ((apply_live | apply_pend) && (jump_cnt_q != 16'hFFFF)) begin
      jump_cnt_q <= jump_cnt_q + 16'd1;
    end
  end

  assign jump_count = jump_cnt_q;
`else
  logic unused_apply;
  assign unused_apply = apply_live | apply_pend;
  assign jump_count   = 16'h0000;
`endif

endmodule
